backend_tx: RTL and testbench
=============================

Name: backend_tx

Overview:
- Downstream stage of the ingress frontend.
- Triggered by the frontend's start/length_be, it reads the staged packet from port B of the 64x256 packet BRAM and replays it on a 256-bit AXI4-Stream master with correct tkeep/tlast.
- Pulses finish back to the frontend when the last byte has been accepted downstream.
- Sustains one beat per clock while tready is high; a 1-cycle BRAM read latency is absorbed by a 2-entry output buffer.

Parameters:
DATA_W, 256, stream/BRAM word width in bits (32 bytes per beat)
ADDR_W, 6, BRAM address width (depth 64 beats, 2048 bytes max)
LEN_W, 16, packet length field width in bytes

Ports:
aclk  in  1  clock
areset  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse from frontend: packet staged at BRAM addresses 0..beats-1
length_be  in  LEN_W  packet length in bytes, valid in the start cycle
finish  out  1  one-cycle pulse: packet fully transmitted
busy  out  1  high from cycle after accepted start until finish cycle inclusive
bram_enb  out  1  BRAM port-B read enable
bram_addrb  out  ADDR_W  BRAM port-B read address
bram_doutb  in  DATA_W  BRAM read data, valid 1 cycle after enb
m_axis_tdata  out  DATA_W  byte 0 at bits [7:0]
m_axis_tkeep  out  DATA_W/8  byte enables
m_axis_tvalid  out  1  beat valid
m_axis_tlast  out  1  last beat of packet
m_axis_tready  in  1  downstream accept

Behaviour:
- Reset values: finish=0, busy=0, bram_enb=0, bram_addrb=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tkeep=0, m_axis_tdata=0. State=IDLE, buffer emptied.
- Reset mid-packet: abandon the packet. No finish and no further beats after reset deasserts.
- Length capture on start in IDLE:
  - len = min(length_be, 2048).
  - beats = ceil(len/32) = (len+31)>>5, range 0..64. Compute in LEN_W+1 bits, no wrap.
  - rem = len[4:0].
- start while busy is ignored. length_be is not resampled.
- FSM:
  - IDLE: on start, if len==0 go to DONE; else go to READ with rd_ptr=0, tx_cnt=0.
  - READ: issue bram_enb with bram_addrb=rd_ptr when (buffered + in_flight) < 2 and rd_ptr < beats; increment rd_ptr. Stay in READ until tx_cnt reaches beats.
  - DONE: finish=1 for exactly one cycle, busy drops in the same cycle, return to IDLE. A start in the DONE cycle is ignored.
- Read data lands in the 2-entry buffer the cycle after enb. The buffer head drives m_axis_*.
- Handshake: beat transfers when tvalid&tready.
  - tdata, tkeep and tlast are held stable while tvalid&!tready.
  - tvalid never drops without a transfer.
- tlast is asserted on beat index beats-1 only.
- tkeep is all ones except on the last beat, where it is (rem==0) ? all ones : (1<<rem)-1.
- Latency: start sampled at T → first enb at T+1 → first tvalid at T+2. With tready held high, the last beat is at T+1+beats and finish at T+2+beats.
- Transition to DONE happens the cycle after the tlast handshake.
- bram_addrb is held at its last value when enb=0.
- len>2048: clamp to 2048 (64 beats, full tkeep on last beat). No other error signalling.

Decomposition:
- frontend_pkg holds:
  - constants DATA_W, BYTES_PER_BEAT=32, BRAM_DEPTH=64, MAX_LEN=2048
  - function len_to_beats(len)
  - function last_tkeep(rem)
  - state encoding localparams IDLE/READ/DONE
- Sub-module axis_skid_fifo2: 2-entry buffer for {tdata, tkeep, tlast} with occupancy count. Used for read-latency absorption and backpressure.

Test Plan:
- length_be=60, tready=1 → 2 beats; beat0 tkeep=0xFFFFFFFF; beat1 tkeep=0x0FFFFFFF, tlast=1; finish at T+4.
- length_be=1514, tready=1 → 48 beats at 1/clk on addrs 0..47; last tkeep=0x000003FF; finish at T+50.
- length_be=64 → exactly 2 beats, last tkeep=0xFFFFFFFF. length_be=2100 → clamped to 64 beats.
- 1514 with random tready (≈50%) → data stable while stalled, no loss or duplication, bytes match the BRAM model, exactly one finish.
- length_be=0 → no tvalid, finish at T+1; a second start while busy → ignored, output unchanged.
- areset asserted after beat 10 of 48 → outputs at reset values immediately. A new 60-byte start after release → clean 2-beat packet with a single finish.

Source files
------------

// File: rtl/frontend_pkg.sv
// Shared constants, state encoding and length helpers for the packet backend.
// Sizes follow the 64 x 256-bit staging BRAM written by the ingress frontend.
package frontend_pkg;

    localparam int DATA_W         = 256;
    localparam int KEEP_W         = DATA_W / 8;
    localparam int ADDR_W         = 6;
    localparam int LEN_W          = 16;
    localparam int BYTES_PER_BEAT = 32;
    localparam int BRAM_DEPTH     = 64;
    localparam int MAX_LEN        = BRAM_DEPTH * BYTES_PER_BEAT;
    localparam int BEAT_W         = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widened by one bit so a length near the top of the field cannot wrap.
    function automatic logic [BEAT_W-1:0] len_to_beats(input logic [LEN_W-1:0] len);
        return BEAT_W'(({1'b0, len} + (LEN_W+1)'(BYTES_PER_BEAT - 1)) >> 5);
    endfunction

    function automatic logic [KEEP_W-1:0] last_tkeep(input logic [4:0] rem);
        if (rem == 5'd0)
            return '1;
        return (KEEP_W'(1) << rem) - KEEP_W'(1);
    endfunction

endpackage

// File: rtl/axis_skid_fifo2.sv
// Two-entry stream buffer with a bypass path: an arriving word is presented in
// the same cycle when the buffer is empty, and parked when the sink stalls.
module axis_skid_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);

    logic [W-1:0] mem_reg [2];
    logic         wr_ptr_reg;
    logic         rd_ptr_reg;
    logic [1:0]   count_reg;
    logic         empty;
    logic         push;
    logic         pop;

    assign empty = (count_reg == 2'd0);
    assign pop   = !empty && out_ready;
    // An arrival consumed straight through the bypass never occupies an entry.
    assign push  = in_valid && !(empty && out_ready);

    assign out_valid = !empty || in_valid;
    assign out_data  = !empty ? mem_reg[rd_ptr_reg] : (in_valid ? in_data : '0);
    assign count     = count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_reg[wr_ptr_reg] <= in_data;
    end

endmodule

// File: rtl/backend_tx.sv
// Replays a packet staged in BRAM port B onto a 256-bit AXI4-Stream master and
// pulses finish once the last beat has been accepted downstream.
module backend_tx
    import frontend_pkg::*;
(
    input  logic              aclk,
    input  logic              areset,
    input  logic              start,
    input  logic [LEN_W-1:0]  length_be,
    output logic              finish,
    output logic              busy,
    output logic              bram_enb,
    output logic [ADDR_W-1:0] bram_addrb,
    input  logic [DATA_W-1:0] bram_doutb,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready
);

    localparam int ENTRY_W = DATA_W + KEEP_W + 1;

    state_t              state_reg;
    state_t              state_next;
    logic [BEAT_W-1:0]   beats_reg;
    logic [BEAT_W-1:0]   rd_ptr_reg;
    logic [BEAT_W-1:0]   tx_cnt_reg;
    logic [4:0]          rem_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic                rd_valid_reg;
    logic [KEEP_W-1:0]   rd_keep_reg;
    logic                rd_last_reg;

    logic [LEN_W-1:0]    len_clamped;
    logic [BEAT_W-1:0]   start_beats;
    logic [1:0]          fifo_count;
    logic                issue;
    logic                issue_last;
    logic                fire;
    logic [ENTRY_W-1:0]  fifo_out;

    assign len_clamped = (length_be > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : length_be;
    assign start_beats = len_to_beats(len_clamped);

    // Never more words outstanding than the buffer can park if the sink stalls.
    assign issue = (state_reg == READ) && (rd_ptr_reg < beats_reg) &&
                   (({1'b0, fifo_count} + {2'b00, rd_valid_reg}) < 3'd2);
    assign issue_last = (rd_ptr_reg == beats_reg - 1'b1);
    assign fire       = m_axis_tvalid && m_axis_tready;

    assign bram_enb   = issue;
    assign bram_addrb = issue ? rd_ptr_reg[ADDR_W-1:0] : addr_reg;
    assign busy       = (state_reg != IDLE);
    assign finish     = (state_reg == DONE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start)
                    state_next = (start_beats == '0) ? DONE : READ;
            end
            READ: begin
                if (fire && (tx_cnt_reg == beats_reg - 1'b1))
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_reg    <= IDLE;
            beats_reg    <= '0;
            rem_reg      <= '0;
            rd_ptr_reg   <= '0;
            tx_cnt_reg   <= '0;
            addr_reg     <= '0;
            rd_valid_reg <= 1'b0;
            rd_keep_reg  <= '0;
            rd_last_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rd_valid_reg <= issue;
            if ((state_reg == IDLE) && start) begin
                beats_reg  <= start_beats;
                rem_reg    <= len_clamped[4:0];
                rd_ptr_reg <= '0;
                tx_cnt_reg <= '0;
            end
            // Beat sideband is decided at read time and travels with the data.
            if (issue) begin
                rd_ptr_reg  <= rd_ptr_reg + 1'b1;
                addr_reg    <= rd_ptr_reg[ADDR_W-1:0];
                rd_keep_reg <= issue_last ? last_tkeep(rem_reg) : '1;
                rd_last_reg <= issue_last;
            end
            if (fire)
                tx_cnt_reg <= tx_cnt_reg + 1'b1;
        end
    end

    axis_skid_fifo2 #(
        .W (ENTRY_W)
    ) u_out_buf (
        .clk       (aclk),
        .rst       (areset),
        .in_valid  (rd_valid_reg),
        .in_data   ({rd_last_reg, rd_keep_reg, bram_doutb}),
        .out_ready (m_axis_tready),
        .out_valid (m_axis_tvalid),
        .out_data  (fifo_out),
        .count     (fifo_count)
    );

    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = fifo_out;

endmodule

// File: tb/tb_backend_tx.sv
// Directed bench for backend_tx: a registered BRAM model feeds the DUT and each
// scenario task checks beats, sideband, timing and data against fixed values.
module tb_backend_tx;

    logic         aclk = 1'b0;
    logic         areset;
    logic         start;
    logic [15:0]  length_be;
    logic         finish;
    logic         busy;
    logic         bram_enb;
    logic [5:0]   bram_addrb;
    logic [255:0] bram_doutb = '0;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tkeep;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready;

    int tests = 0;
    int fails = 0;

    logic [255:0] bram [64];
    logic [255:0] q_data [$];
    logic [31:0]  q_keep [$];
    logic         q_last [$];
    int           q_addr [$];
    int           first_valid_k;
    int           finish_k;
    int           finish_cnt;
    int           stall_err;
    int           post_valid;
    logic         busy_at1;

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (bram_enb)
            bram_doutb <= bram[bram_addrb];
    end

    backend_tx dut (
        .aclk          (aclk),
        .areset        (areset),
        .start         (start),
        .length_be     (length_be),
        .finish        (finish),
        .busy          (busy),
        .bram_enb      (bram_enb),
        .bram_addrb    (bram_addrb),
        .bram_doutb    (bram_doutb),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    function automatic logic [255:0] exp_word(input int a);
        logic [255:0] w;
        for (int j = 0; j < 32; j++)
            w[j*8 +: 8] = 8'(a * 37 + j * 5 + 1);
        return w;
    endfunction

    // Pulse start for one cycle; returns at the first falling edge after it was sampled.
    task automatic start_pkt(input logic [15:0] len);
        @(negedge aclk);
        start     = 1'b1;
        length_be = len;
        @(negedge aclk);
        start     = 1'b0;
    endtask

    // Records one packet; sample k is the k-th cycle after start was sampled.
    task automatic collect(input bit rnd, input int inj_k, input logic [15:0] inj_len, input int extra);
        bit           prev_stall;
        logic [255:0] pd;
        logic [31:0]  pk;
        logic         pl;
        q_data.delete(); q_keep.delete(); q_last.delete(); q_addr.delete();
        first_valid_k = -1; finish_k = -1; finish_cnt = 0;
        stall_err = 0; post_valid = 0; busy_at1 = 1'b0;
        prev_stall = 1'b0; pd = '0; pk = '0; pl = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            if (k > 1)
                @(negedge aclk);
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (k == inj_k) begin
                start     = 1'b1;
                length_be = inj_len;
            end else begin
                start = 1'b0;
            end
            #1;
            if (k == 1)
                busy_at1 = busy;
            if (prev_stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd ||
                               m_axis_tkeep !== pk || m_axis_tlast !== pl))
                stall_err++;
            if (m_axis_tvalid === 1'b1) begin
                if (first_valid_k < 0)
                    first_valid_k = k;
                if (finish_cnt > 0)
                    post_valid++;
            end
            if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
                q_data.push_back(m_axis_tdata);
                q_keep.push_back(m_axis_tkeep);
                q_last.push_back(m_axis_tlast);
            end
            if (bram_enb === 1'b1)
                q_addr.push_back(int'(bram_addrb));
            if (finish === 1'b1) begin
                finish_cnt++;
                if (finish_k < 0)
                    finish_k = k;
            end
            prev_stall = (m_axis_tvalid === 1'b1) && !m_axis_tready;
            pd = m_axis_tdata; pk = m_axis_tkeep; pl = m_axis_tlast;
            if (finish_k >= 0 && k >= finish_k + extra)
                break;
        end
        start = 1'b0;
        m_axis_tready = 1'b1;
    endtask

    task automatic test_reset();
        areset = 1'b1; start = 1'b0; length_be = '0; m_axis_tready = 1'b1;
        repeat (3) @(negedge aclk);
        tests++; if (finish !== 1'b0) begin fails++; $display("FAIL reset_finish: got %b want 0", finish); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (bram_enb !== 1'b0) begin fails++; $display("FAIL reset_enb: got %b want 0", bram_enb); end
        tests++; if (bram_addrb !== 6'd0) begin fails++; $display("FAIL reset_addrb: got %0d want 0", bram_addrb); end
        tests++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        tests++; if (m_axis_tlast !== 1'b0) begin fails++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
        tests++; if (m_axis_tkeep !== 32'h0) begin fails++; $display("FAIL reset_tkeep: got %h want 0", m_axis_tkeep); end
        tests++; if (m_axis_tdata !== 256'h0) begin fails++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
        areset = 1'b0;
        repeat (2) @(negedge aclk);
    endtask

    task automatic test_short_60();
        start_pkt(16'd60);
        collect(1'b0, -1, 16'd0, 4);
        tests++; if (busy_at1 !== 1'b1) begin fails++; $display("FAIL p60_busy: got %b want 1", busy_at1); end
        tests++; if (first_valid_k != 2) begin fails++; $display("FAIL p60_first_valid: got T+%0d want T+2", first_valid_k); end
        tests++; if (finish_k != 4) begin fails++; $display("FAIL p60_finish_time: got T+%0d want T+4", finish_k); end
        tests++; if (finish_cnt != 1) begin fails++; $display("FAIL p60_finish_count: got %0d want 1", finish_cnt); end
        tests++; if (q_data.size() != 2) begin fails++; $display("FAIL p60_beats: got %0d want 2", q_data.size()); end
        if (q_data.size() == 2) begin
            tests++; if (q_keep[0] !== 32'hFFFFFFFF) begin fails++; $display("FAIL p60_keep0: got %h want ffffffff", q_keep[0]); end
            tests++; if (q_keep[1] !== 32'h0FFFFFFF) begin fails++; $display("FAIL p60_keep1: got %h want 0fffffff", q_keep[1]); end
            tests++; if (q_last[0] !== 1'b0) begin fails++; $display("FAIL p60_last0: got %b want 0", q_last[0]); end
            tests++; if (q_last[1] !== 1'b1) begin fails++; $display("FAIL p60_last1: got %b want 1", q_last[1]); end
            for (int i = 0; i < 2; i++) begin
                tests++; if (q_data[i] !== exp_word(i)) begin fails++; $display("FAIL p60_data%0d: got %h want %h", i, q_data[i], exp_word(i)); end
            end
        end
    endtask

    task automatic test_long_1514();
        int bad_addr;
        int nlast;
        start_pkt(16'd1514);
        collect(1'b0, -1, 16'd0, 3);
        tests++; if (q_data.size() != 48) begin fails++; $display("FAIL p1514_beats: got %0d want 48", q_data.size()); end
        tests++; if (finish_k != 50) begin fails++; $display("FAIL p1514_finish_time: got T+%0d want T+50", finish_k); end
        tests++; if (first_valid_k != 2) begin fails++; $display("FAIL p1514_first_valid: got T+%0d want T+2", first_valid_k); end
        tests++; if (q_addr.size() != 48) begin fails++; $display("FAIL p1514_reads: got %0d want 48", q_addr.size()); end
        bad_addr = 0;
        foreach (q_addr[i]) if (q_addr[i] != i) bad_addr++;
        tests++; if (bad_addr != 0) begin fails++; $display("FAIL p1514_addr_order: got %0d out-of-order reads want 0", bad_addr); end
        if (q_data.size() == 48) begin
            nlast = 0;
            foreach (q_last[i]) if (q_last[i]) nlast++;
            tests++; if (nlast != 1 || q_last[47] !== 1'b1) begin fails++; $display("FAIL p1514_tlast: got %0d tlast (last=%b) want 1 on beat 47", nlast, q_last[47]); end
            tests++; if (q_keep[47] !== 32'h000003FF) begin fails++; $display("FAIL p1514_last_keep: got %h want 000003ff", q_keep[47]); end
            tests++; if (q_keep[46] !== 32'hFFFFFFFF) begin fails++; $display("FAIL p1514_keep46: got %h want ffffffff", q_keep[46]); end
            for (int i = 0; i < 48; i++) begin
                tests++; if (q_data[i] !== exp_word(i)) begin fails++; $display("FAIL p1514_data%0d: got %h want %h", i, q_data[i], exp_word(i)); end
            end
        end
    endtask

    task automatic test_boundaries();
        start_pkt(16'd64);
        collect(1'b0, -1, 16'd0, 3);
        tests++; if (q_data.size() != 2) begin fails++; $display("FAIL p64_beats: got %0d want 2", q_data.size()); end
        tests++; if (finish_k != 4) begin fails++; $display("FAIL p64_finish_time: got T+%0d want T+4", finish_k); end
        if (q_data.size() == 2) begin
            tests++; if (q_keep[1] !== 32'hFFFFFFFF || q_last[1] !== 1'b1) begin fails++; $display("FAIL p64_last: got keep %h last %b want ffffffff 1", q_keep[1], q_last[1]); end
        end
        start_pkt(16'd2100);
        collect(1'b0, -1, 16'd0, 3);
        tests++; if (q_data.size() != 64) begin fails++; $display("FAIL p2100_beats: got %0d want 64", q_data.size()); end
        tests++; if (finish_k != 66) begin fails++; $display("FAIL p2100_finish_time: got T+%0d want T+66", finish_k); end
        if (q_data.size() == 64) begin
            tests++; if (q_keep[63] !== 32'hFFFFFFFF || q_last[63] !== 1'b1) begin fails++; $display("FAIL p2100_last: got keep %h last %b want ffffffff 1", q_keep[63], q_last[63]); end
            tests++; if (q_data[63] !== exp_word(63)) begin fails++; $display("FAIL p2100_data63: got %h want %h", q_data[63], exp_word(63)); end
        end
        if (q_addr.size() == 64) begin
            tests++; if (q_addr[63] != 63) begin fails++; $display("FAIL p2100_last_addr: got %0d want 63", q_addr[63]); end
        end
    endtask

    task automatic test_backpressure();
        int nlast;
        start_pkt(16'd1514);
        collect(1'b1, -1, 16'd0, 4);
        tests++; if (q_data.size() != 48) begin fails++; $display("FAIL bp_beats: got %0d want 48", q_data.size()); end
        tests++; if (stall_err != 0) begin fails++; $display("FAIL bp_stall_stable: got %0d unstable stalls want 0", stall_err); end
        tests++; if (finish_cnt != 1) begin fails++; $display("FAIL bp_finish_count: got %0d want 1", finish_cnt); end
        tests++; if (post_valid != 0) begin fails++; $display("FAIL bp_post_valid: got %0d want 0", post_valid); end
        if (q_data.size() == 48) begin
            nlast = 0;
            foreach (q_last[i]) if (q_last[i]) nlast++;
            tests++; if (nlast != 1 || q_last[47] !== 1'b1) begin fails++; $display("FAIL bp_tlast: got %0d tlast want 1 on beat 47", nlast); end
            tests++; if (q_keep[47] !== 32'h000003FF) begin fails++; $display("FAIL bp_last_keep: got %h want 000003ff", q_keep[47]); end
            for (int i = 0; i < 48; i++) begin
                tests++; if (q_data[i] !== exp_word(i)) begin fails++; $display("FAIL bp_data%0d: got %h want %h", i, q_data[i], exp_word(i)); end
            end
        end
    endtask

    task automatic test_zero_and_ignored_start();
        start_pkt(16'd0);
        collect(1'b0, -1, 16'd0, 3);
        tests++; if (finish_k != 1) begin fails++; $display("FAIL zero_finish_time: got T+%0d want T+1", finish_k); end
        tests++; if (first_valid_k != -1) begin fails++; $display("FAIL zero_tvalid: got tvalid at T+%0d want none", first_valid_k); end
        tests++; if (q_addr.size() != 0) begin fails++; $display("FAIL zero_reads: got %0d want 0", q_addr.size()); end
        // Second start while reading: length 200 must not be picked up.
        start_pkt(16'd60);
        collect(1'b0, 2, 16'd200, 4);
        tests++; if (q_data.size() != 2) begin fails++; $display("FAIL busy_start_beats: got %0d want 2", q_data.size()); end
        tests++; if (finish_cnt != 1) begin fails++; $display("FAIL busy_start_finish: got %0d want 1", finish_cnt); end
        if (q_data.size() == 2) begin
            tests++; if (q_keep[1] !== 32'h0FFFFFFF) begin fails++; $display("FAIL busy_start_keep: got %h want 0fffffff", q_keep[1]); end
        end
        // Start raised in the DONE cycle must not launch a packet.
        start_pkt(16'd60);
        collect(1'b0, 4, 16'd60, 6);
        tests++; if (finish_cnt != 1) begin fails++; $display("FAIL done_start_finish: got %0d want 1", finish_cnt); end
        tests++; if (post_valid != 0) begin fails++; $display("FAIL done_start_tvalid: got %0d beats want 0", post_valid); end
        tests++; if (q_addr.size() != 2) begin fails++; $display("FAIL done_start_reads: got %0d want 2", q_addr.size()); end
    endtask

    task automatic test_reset_mid_packet();
        int cnt;
        int stray;
        m_axis_tready = 1'b1;
        start_pkt(16'd1514);
        cnt = 0;
        for (int k = 1; k <= 100; k++) begin
            if (k > 1)
                @(negedge aclk);
            #1;
            if (m_axis_tvalid === 1'b1)
                cnt++;
            if (cnt == 10)
                break;
        end
        tests++; if (cnt != 10) begin fails++; $display("FAIL mid_progress: got %0d beats want 10", cnt); end
        @(posedge aclk);
        #2;
        areset = 1'b1;
        #1;
        tests++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL mid_tvalid: got %b want 0", m_axis_tvalid); end
        tests++; if (busy !== 1'b0 || finish !== 1'b0) begin fails++; $display("FAIL mid_busy_finish: got %b%b want 00", busy, finish); end
        tests++; if (bram_enb !== 1'b0 || bram_addrb !== 6'd0) begin fails++; $display("FAIL mid_bram: got enb %b addr %0d want 0 0", bram_enb, bram_addrb); end
        tests++; if (m_axis_tdata !== 256'h0 || m_axis_tkeep !== 32'h0 || m_axis_tlast !== 1'b0) begin fails++; $display("FAIL mid_stream: got keep %h last %b want 0 0", m_axis_tkeep, m_axis_tlast); end
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        stray = 0;
        repeat (6) begin
            @(negedge aclk);
            if (m_axis_tvalid !== 1'b0 || finish !== 1'b0 || busy !== 1'b0)
                stray++;
        end
        tests++; if (stray != 0) begin fails++; $display("FAIL mid_after_release: got %0d active cycles want 0", stray); end
        start_pkt(16'd60);
        collect(1'b0, -1, 16'd0, 4);
        tests++; if (q_data.size() != 2) begin fails++; $display("FAIL mid_new_beats: got %0d want 2", q_data.size()); end
        tests++; if (finish_cnt != 1 || finish_k != 4) begin fails++; $display("FAIL mid_new_finish: got %0d at T+%0d want 1 at T+4", finish_cnt, finish_k); end
        if (q_data.size() == 2) begin
            tests++; if (q_keep[1] !== 32'h0FFFFFFF || q_last[1] !== 1'b1) begin fails++; $display("FAIL mid_new_last: got keep %h last %b want 0fffffff 1", q_keep[1], q_last[1]); end
            tests++; if (q_data[0] !== exp_word(0)) begin fails++; $display("FAIL mid_new_data0: got %h want %h", q_data[0], exp_word(0)); end
        end
    endtask

    initial begin
        for (int a = 0; a < 64; a++)
            bram[a] = exp_word(a);
        test_reset();
        test_short_60();
        test_long_1514();
        test_boundaries();
        test_backpressure();
        test_zero_and_ignored_start();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
